uart_transmitter: RTL and testbench

//  - Serialises 8-bit bytes into an 8N1 UART frame on a single TX line.
//  - Sits directly downstream of the IO transmit FIFO.
//  - Connect its data_in_* ports to the FIFO's deq_valid / deq_data / deq_ready.
//  - The CPU's memory-mapped UART writes enqueue into that FIFO. This block drains it at the line rate.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_transmitter.sv | 121 ++++++++++++
 tb/tb_uart_transmitter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud-divisor helpers.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t IDLE   = 3'd0;
    localparam uart_state_t START  = 3'd1;
    localparam uart_state_t DATA   = 3'd2;
    localparam uart_state_t PARITY = 3'd3;
    localparam uart_state_t STOP   = 3'd4;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // A one-cycle symbol still needs a 1-bit counter.
    function automatic int symbol_cnt_width(input int set);
        return (set > 1) ? $clog2(set) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol timer: counts CLOCK_FREQ/BAUD_RATE cycles while enabled, held at 0 otherwise.
// symbol_edge is high on the last cycle of each symbol; no backpressure.
module uart_baud_counter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic symbol_edge
);
    import uart_pkg::*;

    localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = symbol_cnt_width(SET);
    localparam logic [CW-1:0] LAST = CW'(SET - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign symbol_edge = enable && (cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (UART_TX_PARITY_EN adds an even-parity symbol); first start-bit cycle follows the fire edge.
// Backpressure: data_in_ready only in IDLE or the last STOP cycle, so frames abut when upstream keeps valid high.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);
    import uart_pkg::*;

    uart_state_t                state, state_nxt;
    logic [UART_DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [2:0]                 bit_idx;
    logic                       symbol_edge;
    logic                       fire;
    logic                       serial_nxt;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_nxt;
`endif

    uart_baud_counter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .enable      (tx_busy),
        .symbol_edge (symbol_edge)
    );

    assign tx_busy       = (state != IDLE);
    assign data_in_ready = (state == IDLE) || (state == STOP && symbol_edge);
    assign fire          = data_in_valid && data_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fire) state_nxt = START;
            START:  if (symbol_edge) state_nxt = DATA;
            DATA: begin
                if (symbol_edge && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (symbol_edge) state_nxt = STOP;
`endif
            STOP:   if (symbol_edge) state_nxt = fire ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_nxt = shift_q;
        if (fire) begin
            shift_nxt = data_in;
        end else if (state == DATA && symbol_edge) begin
            shift_nxt = shift_q >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    assign parity_nxt = fire ? ^data_in : parity_q;
`endif

    // Line level is computed from next state so serial_out can stay a flop without a cycle of lag.
    always_comb begin
        serial_nxt = 1'b1;
        case (state_nxt)
            START:  serial_nxt = 1'b0;
            DATA:   serial_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY: serial_nxt = parity_nxt;
`endif
            default: serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_idx    <= 3'd0;
            serial_out <= 1'b1;
        end else begin
            shift_q    <= shift_nxt;
            serial_out <= serial_nxt;
            if (state == DATA && symbol_edge) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: per-cycle frame model plus literal frame patterns.
module tb_uart_transmitter;

    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int SET = CF / BR;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = 11;
    localparam logic [10:0] EXP_A5 = 11'b1_0_101001010;
    localparam logic [10:0] EXP_C3 = 11'b1_0_110000110;
    localparam logic [10:0] EXP_07 = 11'b1_1_000001110;
    localparam int EXP_LEN   = 110;
    localparam int EXP_ZEROS = 120;
`else
    localparam int NSYM = 10;
    localparam logic [10:0] EXP_A5 = 11'b1_1_101001010;
    localparam logic [10:0] EXP_C3 = 11'b1_1_110000110;
    localparam logic [10:0] EXP_07 = 11'b1_1_000001110;
    localparam int EXP_LEN   = 100;
    localparam int EXP_ZEROS = 100;
`endif
    localparam int FLEN = NSYM * SET;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       tx_busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_transmitter #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a frame is a list of NSYM symbol levels; m_pos is the cycle within it, -1 when idle.
    int          m_pos = -1;
    logic [10:0] m_bits = '1;

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos <= -1;
        end else if (data_in_valid && (m_pos < 0 || m_pos == FLEN - 1)) begin
            m_pos  <= 0;
            m_bits <= frame_of(data_in);
        end else if (m_pos >= 0) begin
            m_pos <= (m_pos == FLEN - 1) ? -1 : m_pos + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("serial_out", int'(serial_out), (m_pos < 0) ? 1 : int'(m_bits[m_pos / SET]));
            check("data_in_ready", int'(data_in_ready), (m_pos < 0 || m_pos == FLEN - 1) ? 1 : 0);
            check("tx_busy", int'(tx_busy), (m_pos >= 0) ? 1 : 0);
        end
    end

    task automatic fire_byte(input logic [7:0] b);
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1 data_in_valid = 1'b0;
    endtask

    // Samples each symbol mid-way; bp=1 presents changing upstream data while the frame is in flight.
    task automatic capture(input bit bp, output logic [10:0] syms, output logic r_pen,
                           output logic r_last, output int busy_cnt);
        syms     = '1;
        busy_cnt = 0;
        r_pen    = 1'b0;
        r_last   = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            if (bp && k == 0) begin
                data_in       = 8'h3C;
                data_in_valid = 1'b1;
            end
            if (bp && k == 50) data_in = 8'hC3;
            if (k % SET == SET / 2) syms[k / SET] = serial_out;
            if (tx_busy) busy_cnt++;
            if (k == FLEN - 2) r_pen = data_in_ready;
            if (k == FLEN - 1) r_last = data_in_ready;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] syms;
        logic        r_pen, r_last;
        int          bcnt;
        logic [7:0]  q[$];
        int          falls[$];
        int          zeros;
        logic        prev;
        logic        will_fire;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset serial_out", int'(serial_out), 1);
        check("reset data_in_ready", int'(data_in_ready), 1);
        check("reset tx_busy", int'(tx_busy), 0);
        rst = 1'b0;

        // Idle line with empty upstream
        repeat (50) @(negedge clk);
        check("idle serial_out", int'(serial_out), 1);
        check("idle tx_busy", int'(tx_busy), 0);

        // Single byte
        fire_byte(8'hA5);
        capture(1'b0, syms, r_pen, r_last, bcnt);
        check("A5 frame symbols", int'(syms), int'(EXP_A5));
        check("A5 ready penultimate", int'(r_pen), 0);
        check("A5 ready last stop", int'(r_last), 1);
        check("A5 frame length", bcnt, EXP_LEN);
        repeat (5) @(negedge clk);

        // Backpressure with changing upstream data, then the byte present at the last STOP cycle
        fire_byte(8'hA5);
        capture(1'b1, syms, r_pen, r_last, bcnt);
        check("bp in-flight A5 frame", int'(syms), int'(EXP_A5));
        check("bp ready last stop", int'(r_last), 1);
        @(posedge clk);
        #1 data_in_valid = 1'b0;
        capture(1'b0, syms, r_pen, r_last, bcnt);
        check("bp next frame C3", int'(syms), int'(EXP_C3));
        repeat (5) @(negedge clk);

        // Back-to-back from a FIFO model
        q = '{8'h00, 8'hFF};
        prev  = 1'b1;
        zeros = 0;
        for (int t = 0; t < 2 * FLEN + 20; t++) begin
            @(negedge clk);
            data_in_valid = (q.size() > 0);
            data_in       = (q.size() > 0) ? q[0] : 8'h00;
            will_fire     = data_in_valid && data_in_ready;
            if (prev && !serial_out) falls.push_back(t);
            if (!serial_out) zeros++;
            prev = serial_out;
            @(posedge clk);
            if (will_fire) void'(q.pop_front());
        end
        data_in_valid = 1'b0;
        check("b2b start bit count", falls.size(), 2);
        if (falls.size() >= 2) check("b2b start spacing", falls[1] - falls[0], EXP_LEN);
        check("b2b zero cycles", zeros, EXP_ZEROS);
        repeat (5) @(negedge clk);

        // Reset mid-frame at cycle 45 (a data-0 symbol of A5)
        fire_byte(8'hA5);
        repeat (46) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset serial_out", int'(serial_out), 1);
        check("midreset tx_busy", int'(tx_busy), 0);
        check("midreset data_in_ready", int'(data_in_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fire_byte(8'h07);
        capture(1'b0, syms, r_pen, r_last, bcnt);
        check("post-reset 07 frame", int'(syms), int'(EXP_07));
        check("post-reset frame length", bcnt, EXP_LEN);

        // Randomized traffic; upstream data changes every cycle
        repeat (3000) begin
            @(negedge clk);
            data_in_valid = ($urandom_range(0, 3) != 0);
            data_in       = 8'($urandom);
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (FLEN + 5) @(negedge clk);
        check("final idle tx_busy", int'(tx_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
